// File: rtl/month_year_counter.sv
// Month/year stage of the millennium calendar: advances on the day counter's
// end-of-month pulse, supports button-driven editing, and drives display digits.
module month_year_counter #(
    parameter int YEAR_MIN = 2000,
    parameter int YEAR_MAX = 2999
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        day_done,
    input  logic        set_mode,
    input  logic        set_sel,
    input  logic        inc,
    input  logic        dec,
    output logic [3:0]  month,
    output logic [11:0] year,
    output logic [3:0]  month_tens,
    output logic [3:0]  month_units,
    output logic [3:0]  year_thou,
    output logic [3:0]  year_hund,
    output logic [3:0]  year_tens,
    output logic [3:0]  year_units,
    output logic        is_leap,
    output logic        year_done,
    output logic        mill_wrap
);

    localparam logic [11:0] YMIN = 12'(YEAR_MIN);
    localparam logic [11:0] YMAX = 12'(YEAR_MAX);

    logic [3:0]  month_reg, month_next;
    logic [11:0] year_reg, year_next;
    logic        year_done_reg, year_done_next;
    logic        mill_wrap_reg, mill_wrap_next;
    logic        inc_q_reg, dec_q_reg;

    logic        inc_p, dec_p;
    logic        month_ok, year_ok;
    logic [3:0]  month_inc, month_dec;
    logic [11:0] year_inc, year_dec;

    assign inc_p = inc & ~inc_q_reg;
    assign dec_p = dec & ~dec_q_reg;

    assign month_ok = (month_reg >= 4'd1) && (month_reg <= 4'd12);
    assign year_ok  = (year_reg >= YMIN) && (year_reg <= YMAX);

    assign month_inc = (month_reg == 4'd12) ? 4'd1  : month_reg + 4'd1;
    assign month_dec = (month_reg == 4'd1)  ? 4'd12 : month_reg - 4'd1;
    assign year_inc  = (year_reg == YMAX)   ? YMIN  : year_reg + 12'd1;
    assign year_dec  = (year_reg == YMIN)   ? YMAX  : year_reg - 12'd1;

    // Any update first repairs an out-of-range field instead of stepping it.
    always_comb begin
        month_next     = month_reg;
        year_next      = year_reg;
        year_done_next = 1'b0;
        mill_wrap_next = 1'b0;
        if (set_mode) begin
            if (inc_p ^ dec_p) begin
                if (!month_ok) begin
                    month_next = 4'd1;
                end
                if (!year_ok) begin
                    year_next = YMIN;
                end
                if (!set_sel) begin
                    if (month_ok) begin
                        month_next = inc_p ? month_inc : month_dec;
                    end
                end else begin
                    if (year_ok) begin
                        year_next = inc_p ? year_inc : year_dec;
                    end
                end
            end
        end else if (day_done) begin
            if (!year_ok) begin
                year_next = YMIN;
            end
            if (!month_ok) begin
                month_next = 4'd1;
            end else if (month_reg != 4'd12) begin
                month_next = month_reg + 4'd1;
            end else begin
                month_next = 4'd1;
                if (year_ok) begin
                    year_next      = year_inc;
                    year_done_next = 1'b1;
                    mill_wrap_next = (year_reg == YMAX);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            month_reg     <= 4'd1;
            year_reg      <= YMIN;
            year_done_reg <= 1'b0;
            mill_wrap_reg <= 1'b0;
            inc_q_reg     <= 1'b0;
            dec_q_reg     <= 1'b0;
        end else begin
            month_reg     <= month_next;
            year_reg      <= year_next;
            year_done_reg <= year_done_next;
            mill_wrap_reg <= mill_wrap_next;
            inc_q_reg     <= inc;
            dec_q_reg     <= dec;
        end
    end

    // Shift-add-3 binary to BCD; the thousands digit of a 12-bit value never
    // reaches 5 before the final shift, so only the lower three nibbles adjust.
    logic [15:0] dd_stage [0:12];
    assign dd_stage[0] = 16'd0;

    generate
        for (genvar gi = 0; gi < 12; gi++) begin : g_dabble
            logic [14:0] adj;
            for (genvar gn = 0; gn < 3; gn++) begin : g_nib
                assign adj[4*gn +: 4] = (dd_stage[gi][4*gn +: 4] >= 4'd5)
                                        ? dd_stage[gi][4*gn +: 4] + 4'd3
                                        : dd_stage[gi][4*gn +: 4];
            end
            assign adj[14:12]      = dd_stage[gi][14:12];
            assign dd_stage[gi+1]  = {adj, year_reg[11-gi]};
        end
    endgenerate

    assign year_thou  = dd_stage[12][15:12];
    assign year_hund  = dd_stage[12][11:8];
    assign year_tens  = dd_stage[12][7:4];
    assign year_units = dd_stage[12][3:0];

    assign month_tens  = (month_reg >= 4'd10) ? 4'd1 : 4'd0;
    assign month_units = (month_reg >= 4'd10) ? month_reg - 4'd10 : month_reg;

    // Century years end in "00"; those are leap only if also divisible by 16 (400 = 16*25).
    logic century;
    assign century = (year_tens == 4'd0) && (year_units == 4'd0);
    assign is_leap = century ? (year_reg[3:0] == 4'd0) : (year_reg[1:0] == 2'd0);

    assign month     = month_reg;
    assign year      = year_reg;
    assign year_done = year_done_reg;
    assign mill_wrap = mill_wrap_reg;

endmodule

// File: tb/tb_month_year_counter.sv
// Self-checking bench for month_year_counter: directed scenarios plus random
// stimulus against a calendar-arithmetic reference model.
module tb_month_year_counter;

    localparam int YMIN = 2000;
    localparam int YMAX = 2999;
    localparam int SPAN = YMAX - YMIN + 1;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        day_done = 1'b0;
    logic        set_mode = 1'b0;
    logic        set_sel = 1'b0;
    logic        inc = 1'b0;
    logic        dec = 1'b0;
    logic [3:0]  month;
    logic [11:0] year;
    logic [3:0]  month_tens, month_units;
    logic [3:0]  year_thou, year_hund, year_tens, year_units;
    logic        is_leap, year_done, mill_wrap;

    int n_cmp = 0;
    int n_err = 0;

    int m_month = 1;
    int m_year  = YMIN;
    bit m_inc_q = 1'b0;
    bit m_dec_q = 1'b0;
    bit exp_yd  = 1'b0;
    bit exp_mw  = 1'b0;

    month_year_counter #(.YEAR_MIN(YMIN), .YEAR_MAX(YMAX)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .day_done    (day_done),
        .set_mode    (set_mode),
        .set_sel     (set_sel),
        .inc         (inc),
        .dec         (dec),
        .month       (month),
        .year        (year),
        .month_tens  (month_tens),
        .month_units (month_units),
        .year_thou   (year_thou),
        .year_hund   (year_hund),
        .year_tens   (year_tens),
        .year_units  (year_units),
        .is_leap     (is_leap),
        .year_done   (year_done),
        .mill_wrap   (mill_wrap)
    );

    always #5 clk = ~clk;

    function automatic bit leap_of(input int y);
        return (y % 400 == 0) || ((y % 4 == 0) && (y % 100 != 0));
    endfunction

    task automatic model_reset();
        m_month = 1;
        m_year  = YMIN;
        m_inc_q = 1'b0;
        m_dec_q = 1'b0;
        exp_yd  = 1'b0;
        exp_mw  = 1'b0;
    endtask

    // Drive one clock of inputs and advance the calendar model by the same event.
    task automatic cyc(input bit dd, input bit sm, input bit ss, input bit i, input bit d);
        bit ip, dp;
        int idx;
        day_done = dd;
        set_mode = sm;
        set_sel  = ss;
        inc      = i;
        dec      = d;
        ip = i && !m_inc_q;
        dp = d && !m_dec_q;
        m_inc_q = i;
        m_dec_q = d;
        exp_yd = 1'b0;
        exp_mw = 1'b0;
        if (!sm) begin
            if (dd) begin
                if (m_month == 12) begin
                    exp_yd = 1'b1;
                    exp_mw = (m_year == YMAX);
                end
                idx = ((m_year - YMIN) * 12 + (m_month - 1) + 1) % (SPAN * 12);
                m_year  = YMIN + idx / 12;
                m_month = idx % 12 + 1;
            end
        end else if (ip != dp) begin
            if (!ss)
                m_month = ((m_month - 1 + (ip ? 1 : 11)) % 12) + 1;
            else
                m_year = YMIN + ((m_year - YMIN + (ip ? 1 : SPAN - 1)) % SPAN);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic press(input bit ss, input bit up);
        cyc(1'b0, 1'b1, ss, up, !up);
        cyc(1'b0, 1'b1, ss, 1'b0, 1'b0);
    endtask

    task automatic goto(input int mon, input int yr);
        while (m_year != yr) press(1'b1, yr > m_year);
        while (m_month != mon) press(1'b0, mon > m_month);
    endtask

    task automatic test_reset();
        #2 rstn = 1'b0;
        #1;
        n_cmp++; if (month !== 4'd1) begin n_err++; $display("FAIL reset_month: got %0d want 1", month); end
        n_cmp++; if (year !== 12'd2000) begin n_err++; $display("FAIL reset_year: got %0d want 2000", year); end
        n_cmp++; if (year_done !== 1'b0) begin n_err++; $display("FAIL reset_year_done: got %b want 0", year_done); end
        n_cmp++; if (mill_wrap !== 1'b0) begin n_err++; $display("FAIL reset_mill_wrap: got %b want 0", mill_wrap); end
        $display("reset: month=%0d year=%0d", month, year);
        @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        n_cmp++; if (month !== 4'd1 || year !== 12'd2000) begin
            n_err++; $display("FAIL reset_idle: got %0d/%0d want 1/2000", month, year);
        end
    endtask

    task automatic test_run_months();
        for (int k = 0; k < 11; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            $display("run day_done #%0d: month=%0d year=%0d yd=%0d", k + 1, month, year, year_done);
            n_cmp++; if (month !== 4'(m_month)) begin n_err++; $display("FAIL run_month: got %0d want %0d", month, m_month); end
            n_cmp++; if (year !== 12'(m_year)) begin n_err++; $display("FAIL run_year: got %0d want %0d", year, m_year); end
            n_cmp++; if (year_done !== 1'b0) begin n_err++; $display("FAIL run_year_done: got %b want 0", year_done); end
        end
        n_cmp++; if (month_tens !== 4'd1 || month_units !== 4'd2) begin
            n_err++; $display("FAIL run_month_bcd: got %0d%0d want 12", month_tens, month_units);
        end
    endtask

    task automatic test_year_rollover();
        goto(12, 2023);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("rollover 12/2023: month=%0d year=%0d yd=%0d leap=%0d", month, year, year_done, is_leap);
        n_cmp++; if (month !== 4'd1 || year !== 12'd2024) begin n_err++; $display("FAIL roll_date: got %0d/%0d want 1/2024", month, year); end
        n_cmp++; if (year_done !== 1'b1 || mill_wrap !== 1'b0) begin n_err++; $display("FAIL roll_pulse: got yd=%b mw=%b want 1/0", year_done, mill_wrap); end
        n_cmp++; if (is_leap !== 1'b1) begin n_err++; $display("FAIL roll_leap: got %b want 1", is_leap); end
        n_cmp++; if ({year_thou, year_hund, year_tens, year_units} !== 16'h2024) begin
            n_err++; $display("FAIL roll_digits: got %0d%0d%0d%0d want 2024", year_thou, year_hund, year_tens, year_units);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (year_done !== 1'b0) begin n_err++; $display("FAIL roll_pulse_width: got %b want 0", year_done); end
    endtask

    task automatic test_mill_wrap();
        goto(12, 2999);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("wrap 12/2999: month=%0d year=%0d yd=%0d mw=%0d", month, year, year_done, mill_wrap);
        n_cmp++; if (month !== 4'd1 || year !== 12'd2000) begin n_err++; $display("FAIL wrap_date: got %0d/%0d want 1/2000", month, year); end
        n_cmp++; if (year_done !== 1'b1 || mill_wrap !== 1'b1) begin n_err++; $display("FAIL wrap_pulse: got yd=%b mw=%b want 1/1", year_done, mill_wrap); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (year_done !== 1'b0 || mill_wrap !== 1'b0) begin n_err++; $display("FAIL wrap_pulse_width: got yd=%b mw=%b want 0/0", year_done, mill_wrap); end
    endtask

    task automatic test_set_year();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        $display("set year dec: year=%0d", year);
        n_cmp++; if (year !== 12'd2999) begin n_err++; $display("FAIL set_year_dec: got %0d want 2999", year); end
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        $display("set year inc: year=%0d", year);
        n_cmp++; if (year !== 12'd2000) begin n_err++; $display("FAIL set_year_inc: got %0d want 2000", year); end
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            $display("set year inc held clk %0d: year=%0d", k, year);
            n_cmp++; if (year !== 12'd2001) begin n_err++; $display("FAIL set_year_held: got %0d want 2001", year); end
        end
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        $display("set mode day_done: month=%0d year=%0d yd=%0d", month, year, year_done);
        n_cmp++; if (month !== 4'(m_month) || year !== 12'd2001 || year_done !== 1'b0) begin
            n_err++; $display("FAIL set_ignores_day_done: got %0d/%0d yd=%b want %0d/2001 yd=0", month, year, year_done, m_month);
        end
    endtask

    task automatic test_set_month();
        goto(1, m_year);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        $display("set month dec: month=%0d year=%0d", month, year);
        n_cmp++; if (month !== 4'd12) begin n_err++; $display("FAIL set_month_dec: got %0d want 12", month); end
        n_cmp++; if (year !== 12'(m_year)) begin n_err++; $display("FAIL set_month_year: got %0d want %0d", year, m_year); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        $display("set month inc+dec: month=%0d", month);
        n_cmp++; if (month !== 4'd12) begin n_err++; $display("FAIL set_month_both: got %0d want 12", month); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        $display("set month inc: month=%0d", month);
        n_cmp++; if (month !== 4'd1) begin n_err++; $display("FAIL set_month_wrap_up: got %0d want 1", month); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_leap();
        int ys[4] = '{2100, 2400, 2900, 2996};
        bit ls[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            goto(m_month, ys[k]);
            $display("leap year=%0d is_leap=%0d", year, is_leap);
            n_cmp++; if (year !== 12'(ys[k])) begin n_err++; $display("FAIL leap_year: got %0d want %0d", year, ys[k]); end
            n_cmp++; if (is_leap !== ls[k]) begin n_err++; $display("FAIL leap_flag %0d: got %b want %b", ys[k], is_leap, ls[k]); end
            n_cmp++; if (year_hund !== 4'((ys[k] / 100) % 10) || year_tens !== 4'((ys[k] / 10) % 10)) begin
                n_err++; $display("FAIL leap_digits %0d: got hund=%0d tens=%0d", ys[k], year_hund, year_tens);
            end
        end
    endtask

    task automatic test_reset_mid();
        goto(12, m_year);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (year_done !== 1'b1) begin n_err++; $display("FAIL mid_pending: got %b want 1", year_done); end
        #2 rstn = 1'b0;
        #1;
        $display("reset mid: month=%0d year=%0d yd=%0d", month, year, year_done);
        n_cmp++; if (month !== 4'd1 || year !== 12'd2000) begin n_err++; $display("FAIL mid_reset_date: got %0d/%0d want 1/2000", month, year); end
        n_cmp++; if (year_done !== 1'b0 || mill_wrap !== 1'b0) begin n_err++; $display("FAIL mid_reset_pulse: got yd=%b mw=%b want 0/0", year_done, mill_wrap); end
        day_done = 1'b0;
        @(negedge clk) rstn = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        bit sm, ss;
        sm = 1'b0;
        ss = 1'b0;
        goto(9, 2998);
        for (int k = 0; k < 1500; k++) begin
            if (k % 40 == 0) begin
                sm = ($urandom_range(0, 2) == 0);
                ss = $urandom_range(0, 1) != 0;
            end
            cyc($urandom_range(0, 1) != 0, sm, ss,
                $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            $display("rnd %0d: sm=%0d ss=%0d dd=%0d inc=%0d dec=%0d -> %0d/%0d yd=%0d mw=%0d",
                     k, sm, ss, day_done, inc, dec, month, year, year_done, mill_wrap);
            n_cmp++; if (month !== 4'(m_month)) begin n_err++; $display("FAIL rnd_month: got %0d want %0d", month, m_month); end
            n_cmp++; if (year !== 12'(m_year)) begin n_err++; $display("FAIL rnd_year: got %0d want %0d", year, m_year); end
            n_cmp++; if (month_tens !== 4'(m_month / 10) || month_units !== 4'(m_month % 10)) begin
                n_err++; $display("FAIL rnd_month_bcd: got %0d%0d want %0d", month_tens, month_units, m_month);
            end
            n_cmp++; if (year_thou !== 4'(m_year / 1000) || year_hund !== 4'((m_year / 100) % 10)
                         || year_tens !== 4'((m_year / 10) % 10) || year_units !== 4'(m_year % 10)) begin
                n_err++; $display("FAIL rnd_year_bcd: got %0d%0d%0d%0d want %0d", year_thou, year_hund, year_tens, year_units, m_year);
            end
            n_cmp++; if (is_leap !== leap_of(m_year)) begin n_err++; $display("FAIL rnd_leap %0d: got %b want %b", m_year, is_leap, leap_of(m_year)); end
            n_cmp++; if (year_done !== exp_yd) begin n_err++; $display("FAIL rnd_year_done: got %b want %b", year_done, exp_yd); end
            n_cmp++; if (mill_wrap !== exp_mw) begin n_err++; $display("FAIL rnd_mill_wrap: got %b want %b", mill_wrap, exp_mw); end
        end
    endtask

    initial begin
        test_reset();
        test_run_months();
        test_year_rollover();
        test_mill_wrap();
        test_set_year();
        test_set_month();
        test_leap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/month_year_counter.md
Name: month_year_counter

Overview:
- Calendar stage directly downstream of the day counter in the millennium clock.
- Consumes the day counter's end-of-month pulse and advances month 1..12 and year YEAR_MIN..YEAR_MAX.
- Feeds month, year and leap status back to the day counter so it can compute days-in-month.
- Supports manual setting of month or year via inc/dec buttons, and provides decimal digits for display.

Parameters:
- YEAR_MIN, 2000, lowest year and the reset value of the year register.
- YEAR_MAX, 2999, highest year; the year wraps between YEAR_MAX and YEAR_MIN.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- day_done  input  1  end-of-month pulse from the day counter, one clk wide.
- set_mode  input  1  1 = setting mode; day_done is ignored while set.
- set_sel  input  1  field under edit: 0 = month, 1 = year.
- inc  input  1  increment button level, synchronous to clk; edge-detected internally.
- dec  input  1  decrement button level, synchronous to clk; edge-detected internally.
- month  output  4  current month, binary 1..12.
- year  output  12  current year, binary YEAR_MIN..YEAR_MAX.
- month_tens  output  4  BCD tens digit of month, 0..1.
- month_units  output  4  BCD units digit of month, 0..9.
- year_thou, year_hund, year_tens, year_units  output  4 each  BCD digits of year.
- is_leap  output  1  1 when year is a leap year.
- year_done  output  1  one-clk pulse when the year advances from a Dec rollover in run mode.
- mill_wrap  output  1  one-clk pulse when year wraps YEAR_MAX -> YEAR_MIN in run mode.

Behaviour:
- Reset (async, rstn=0): month=1, year=YEAR_MIN, year_done=0, mill_wrap=0, inc/dec edge registers=0.
- After reset release, nothing changes until a qualifying event.
- Edge detect:
  - inc_p = inc & ~inc_q; dec_p = dec & ~dec_q.
  - inc_q and dec_q are registered copies of inc and dec, updated every clk regardless of mode.
- Run mode (set_mode=0), on day_done=1:
  - month<12: month+1.
  - month=12 and year<YEAR_MAX: month=1, year+1, year_done pulses.
  - month=12 and year=YEAR_MAX: month=1, year=YEAR_MIN, year_done and mill_wrap both pulse.
  - inc/dec edges are ignored in run mode.
- Set mode (set_mode=1):
  - day_done is ignored.
  - set_sel=0: inc_p gives month+1 with 12->1 wrap; dec_p gives month-1 with 1->12 wrap. Year is untouched; no carry.
  - set_sel=1: inc_p gives year+1 with YEAR_MAX->YEAR_MIN wrap; dec_p gives year-1 with YEAR_MIN->YEAR_MAX wrap. Month is untouched.
  - year_done and mill_wrap never pulse in set mode.
  - inc_p and dec_p in the same clk: no change.
  - A held button produces exactly one step.
- Latency:
  - month and year update on the clk edge that samples the qualifying event.
  - year_done and mill_wrap are registered and assert in the cycle following that edge, for exactly one clk.
- Derived outputs (combinational from month/year registers, valid in the same cycle):
  - BCD digits: year digits by binary-to-BCD conversion, e.g. 2024 -> 2,0,2,4. month 10..12 gives tens=1.
  - is_leap = (year%400==0) | (year%4==0 & year%100!=0). Within 2000..2999: leap for 2000, 2400, 2800; not leap for 2100, 2200, 2300, 2500, 2600, 2700, 2900.
- Robustness:
  - An illegal month (0 or 13..15) is never produced.
  - If an illegal month is reached via a glitch, the next update forces month=1.
  - A year outside the range is forced to YEAR_MIN on the next update.
- Reset mid-operation: immediate return to reset values; any pending pulse is cleared.
- set_mode toggling: takes effect on the next clk. An edge detected in the same cycle as the set_mode rise is honoured because set_mode is sampled together with it.

Test Plan:
- Reset, then 11 day_done pulses -> month steps 1..12, year=2000, year_done stays 0, month_tens/units=1/2 at month 12.
- month=12, year=2023, day_done -> month=1, year=2024, year_done=1 for one clk, is_leap=1, digits 2,0,2,4.
- month=12, year=2999, day_done -> month=1, year=2000, year_done and mill_wrap each pulse once.
- set_mode=1, set_sel=1, year=2000, dec rise -> 2999; inc rise -> 2000; inc held 10 clks -> single step; day_done in set mode -> no change.
- set_mode=1, set_sel=0, month=1, dec rise -> 12; inc and dec rise together -> unchanged; year unchanged throughout.
- Leap checks via set: years 2100, 2400, 2900, 2996 -> is_leap 0, 1, 0, 1; rstn asserted mid-sequence -> month=1, year=2000 immediately.
